pkt_header_parser_v2: RTL

// - Parametrised successor of the pipeline header parser. Sits inline on the 64b-class

---
 rtl/pkt_parser_pkg.sv | 30 +++
 rtl/pkt_header_parser_v2_skid.sv | 72 +++++++
 rtl/pkt_header_parser_v2.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pkt_parser_pkg.sv
// Shared types and constants for the packet header parser.
package pkt_parser_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2
  } state_e;

  localparam int CTRL_DATA = 'h0;
  localparam int CTRL_IOQ  = 'hFF;

  // The word index is tracked at a fixed 32-bit width so the header and field
  // compares stay exact. Each instance saturates the exported data_count to its
  // own CNT_W.
  localparam int TAG_CNT_W = 32;

  typedef struct packed {
    logic                 mhdr;
    logic                 payload;
    logic                 eop;
    logic                 field_hit;
    logic [TAG_CNT_W-1:0] count;
  } word_tag_t;

  function automatic logic [TAG_CNT_W-1:0] sat_inc(input logic [TAG_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pkt_header_parser_v2_skid.sv
// Two-entry registered valid/ready skid buffer. Entry 1 drives the output
// directly, which gives 1-cycle latency. Entry 2 absorbs the word that arrives
// in the cycle the consumer stalls. in_rdy is registered and reports whether
// entry 2 is empty.
module pkt_skid_buf #(
  parameter int W = 8
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic [W-1:0] in_data,
  input  logic         in_vld,
  output logic         in_rdy,
  output logic [W-1:0] out_data,
  output logic         out_vld,
  input  logic         out_rdy
);

  logic [W-1:0] main_q, main_d, skid_q, skid_d;
  logic         main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic         rdy_q, rdy_d;
  logic         push, pop;

  // Next-state for the two entries. When entry 2 is full, in_rdy is already
  // low, so a pop only refills entry 1 from entry 2.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    push       = in_vld && rdy_q;
    pop        = main_vld_q && out_rdy;
    if (skid_vld_q) begin
      if (pop) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (push) begin
      if (!main_vld_q || pop) begin
        main_d     = in_data;
        main_vld_d = 1'b1;
      end else begin
        skid_d     = in_data;
        skid_vld_d = 1'b1;
      end
    end else if (pop) begin
      main_vld_d = 1'b0;
    end
    rdy_d = !skid_vld_d;
  end

  // Storage registers. rdy_q resets low so in_rdy is 0 while reset is held.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
    end
  end

  assign in_rdy   = rdy_q;
  assign out_data = main_q;
  assign out_vld  = main_vld_q;

endmodule

// File: rtl/pkt_header_parser_v2.sv
// Inline packet header parser. Words are classified as they enter, and the tag
// travels through the skid buffer with the word. Field capture, short-packet
// detection and packet counting act on the output handshake.
//
// state | meaning
// IDLE  | between packets; ctrl!=0 words are module headers
// HDR   | inside the packet header (data index <= H)
// PAY   | inside the payload; the next ctrl!=0 word is the EOP
module pkt_header_parser_v2
  import pkt_parser_pkg::*;
#(
  parameter int DWIDTH     = 64,
  parameter int CTRL_WIDTH = DWIDTH / 8,
  parameter int FIELD_WORD = 1,
  parameter int FIELD_LSB  = 16,
  parameter int FIELD_W    = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic [DWIDTH-1:0]     in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DWIDTH-1:0]     out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic [7:0]            i_hdr_words,
  output logic [CNT_W-1:0]      data_count,
  output logic                  o_inside_payload,
  output logic [FIELD_W-1:0]    o_field,
  output logic                  o_field_valid,
  output logic [31:0]           o_pkt_count,
  output logic                  o_err_short
);

  localparam int TAG_W = $bits(word_tag_t);
  localparam int BUF_W = CTRL_WIDTH + DWIDTH + TAG_W;
  localparam logic [TAG_CNT_W-1:0] CNT_MAX   = TAG_CNT_W'((64'd1 << CNT_W) - 64'd1);
  localparam logic [TAG_CNT_W-1:0] FIELD_IDX = TAG_CNT_W'(FIELD_WORD + 1);

  state_e                  state_q, state_d;
  logic [TAG_CNT_W-1:0]    count_q, count_d;
  logic [7:0]              hdr_len_q, hdr_len_d;
  word_tag_t               in_tag, out_tag;
  logic                    accept, is_data;
  logic [BUF_W-1:0]        buf_in, buf_out;
  logic [CTRL_WIDTH-1:0]   buf_ctrl;
  logic [DWIDTH-1:0]       buf_data;
  logic                    out_fire;
  logic [31:0]             pkt_cnt_q, pkt_cnt_d;
  logic [FIELD_W-1:0]      field_q, field_d;
  logic                    got_field_q, got_field_d;

  // Input-side classification and FSM next state. The state advances only on an accepted word.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hdr_len_d = hdr_len_q;
    in_tag    = '0;
    accept    = in_wr && in_rdy;
    is_data   = (in_ctrl == CTRL_WIDTH'(CTRL_DATA));
    case (state_q)
      IDLE: begin
        if (is_data) begin
          count_d        = TAG_CNT_W'(1);
          hdr_len_d      = i_hdr_words;
          in_tag.count   = TAG_CNT_W'(1);
          in_tag.payload = (i_hdr_words == 8'd0);
          state_d        = (i_hdr_words == 8'd0) ? PAY : HDR;
        end else begin
          in_tag.mhdr = 1'b1;
        end
      end
      HDR, PAY: begin
        count_d      = sat_inc(count_q);
        in_tag.count = count_d;
        if (is_data) begin
          in_tag.payload = (state_q == PAY) || (count_q >= TAG_CNT_W'(hdr_len_q));
          if (in_tag.payload) state_d = PAY;
        end else begin
          in_tag.eop     = 1'b1;
          in_tag.payload = (state_q == PAY);
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_tag.field_hit = is_data && (in_tag.count == FIELD_IDX);
    if (!accept) begin
      state_d   = state_q;
      count_d   = count_q;
      hdr_len_d = hdr_len_q;
    end
  end

  // Input-stage FSM registers.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      hdr_len_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hdr_len_q <= hdr_len_d;
    end
  end

  assign buf_in = {in_ctrl, in_data, in_tag};

  pkt_skid_buf #(.W(BUF_W)) u_skid (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .in_data   (buf_in),
    .in_vld    (in_wr),
    .in_rdy    (in_rdy),
    .out_data  (buf_out),
    .out_vld   (out_wr),
    .out_rdy   (out_rdy)
  );

  assign {buf_ctrl, buf_data, out_tag} = buf_out;
  assign out_data = buf_data;
  assign out_ctrl = buf_ctrl;
  assign out_fire = out_wr && out_rdy;

  // Output-side events. o_field shows the new value in the same cycle as the valid pulse.
  always_comb begin
    o_field_valid = out_fire && out_tag.field_hit;
    o_err_short   = out_fire && out_tag.eop && !got_field_q;
    field_d       = o_field_valid ? buf_data[FIELD_LSB +: FIELD_W] : field_q;
    pkt_cnt_d     = pkt_cnt_q + {31'd0, out_fire && out_tag.eop};
    got_field_d   = got_field_q;
    if (out_fire && out_tag.eop) got_field_d = 1'b0;
    else if (o_field_valid)      got_field_d = 1'b1;
  end

  // Output-side registers: packet counter, held field value, per-packet field flag.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pkt_cnt_q   <= '0;
      field_q     <= '0;
      got_field_q <= 1'b0;
    end else begin
      pkt_cnt_q   <= pkt_cnt_d;
      field_q     <= field_d;
      got_field_q <= got_field_d;
    end
  end

  assign o_field          = field_d;
  assign o_pkt_count      = pkt_cnt_q;
  assign o_inside_payload = out_wr && out_tag.payload && !out_tag.mhdr;
  assign data_count       = (!out_wr || out_tag.mhdr) ? '0 :
                            (out_tag.count >= CNT_MAX) ? CNT_MAX[CNT_W-1:0] :
                            out_tag.count[CNT_W-1:0];

endmodule
